cla_pipe_addsub: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Stage 1 computes bit-level and group-level propagate/generate terms. Stage 2 resolves the group carries by lookahead, then forms the sum, carry-out and signed overflow.
- Generalises the 4-bit CLA to WIDTH bits in GROUP-bit lookahead groups, adds a subtract mode, and sits in datapaths that need a registered, back-pressurable adder.

---
 rtl/cla_pipe_addsub.sv | 160 ++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module  : cla_pipe_addsub
// Brief   : Two-stage pipelined carry-lookahead adder/subtractor, valid/ready.
//           Define CLA_PIPE_SATURATE_EN to saturate SUM on signed overflow.
// Revision: 1.0
// ============================================================================
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] beff, p, g;
  logic [NGRP-1:0]  gp, gg;
  logic             c0, t1;

  logic             s1_valid, s1_c0;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NGRP-1:0]  s1_gp, s1_gg;

  logic             s2_ready;
  logic [NGRP:0]    ggc, gc;
  logic [WIDTH:0]   gx, carry;
  logic             t2, t3;
  logic [WIDTH-1:0] sum_d, res_d;
  logic             ovf_d;

  assign s2_ready = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_ready;

  // Stage 1: bit and group propagate/generate
  assign beff = sub ? ~b : b;
  assign c0   = cin ^ sub;
  assign p    = a ^ beff;
  assign g    = a & beff;

  always_comb begin
    gp = '0;
    gg = '0;
    t1 = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      gp[k] = &p[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        t1 = g[k*GROUP+j];
        for (int m = j + 1; m < GROUP; m++) t1 = t1 & p[k*GROUP+m];
        gg[k] = gg[k] | t1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_c0    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p;
        s1_g  <= g;
        s1_gp <= gp;
        s1_gg <= gg;
        s1_c0 <= c0;
      end
    end
  end

  // Stage 2: flat sum-of-products lookahead, both across groups and within each group
  assign ggc = {s1_gg, s1_c0};
  assign gx  = {s1_g, 1'b0};

  always_comb begin
    gc    = '0;
    t2    = 1'b0;
    gc[0] = s1_c0;
    for (int k = 1; k <= NGRP; k++) begin
      for (int j = 0; j <= k; j++) begin
        t2 = ggc[j];
        for (int m = j; m < k; m++) t2 = t2 & s1_gp[m];
        gc[k] = gc[k] | t2;
      end
    end
  end

  always_comb begin
    carry = '0;
    t3    = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        for (int m = 0; m <= j; m++) begin
          t3 = (m == 0) ? gc[k] : gx[k*GROUP+m];
          for (int n = m; n < j; n++) t3 = t3 & s1_p[k*GROUP+n];
          carry[k*GROUP+j] = carry[k*GROUP+j] | t3;
        end
      end
    end
    carry[WIDTH] = gc[NGRP];
  end

  assign sum_d = s1_p ^ carry[WIDTH-1:0];
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef CLA_PIPE_SATURATE_EN
  logic s1_a_msb, s1_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (in_ready && in_valid) begin
      s1_a_msb <= a[WIDTH-1];
      s1_b_msb <= beff[WIDTH-1];
    end
  end

  // Overflow only occurs with like-signed operands; both negative means negative overflow
  assign res_d = !ovf_d ? sum_d :
                 (s1_a_msb & s1_b_msb) ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_d = sum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_d;
        cout <= carry[WIDTH];
        ovf  <= ovf_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_cla_pipe_addsub
// Brief   : Directed-vector self-checking bench for cla_pipe_addsub (16/4).
// Revision: 1.0
// ============================================================================
module tb_cla_pipe_addsub;

  logic        clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  int          n_cmp = 0;
  int          n_bad = 0;

  cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] ye, s;
    logic [16:0] r;
    logic        ov;
    ye = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {16'd0, ci ^ sb};
    ov = (x[15] == ye[15]) && (r[15] != x[15]);
    s  = r[15:0];
`ifdef CLA_PIPE_SATURATE_EN
    if (ov) s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, r[16], s};
  endfunction

  // One isolated operation; returns out_valid one cycle after acceptance and the result two cycles after
  task automatic run_one(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, output logic early, output logic vld,
                         output logic [15:0] s, output logic co, output logic ov);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 early = out_valid;
    @(negedge clk);
    #1 vld = out_valid; s = sum; co = cout; ov = ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_cmp++; if ({cout, ovf} !== 2'b00) begin n_bad++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_carry_chain;
    logic e, v, co, ov;
    logic [15:0] s;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, v, s, co, ov);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL chain_latency_early: got %b want 0", e); end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL chain_latency_valid: got %b want 1", v); end
    n_cmp++; if ({ov, co, s} !== {1'b0, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL chain_result: got ovf=%b cout=%b sum=%h want 0 1 0000", ov, co, s); end
    run_one(16'h1234, 16'h1111, 1'b1, 1'b0, e, v, s, co, ov);
    n_cmp++; if ({v, ov, co, s} !== {1'b1, 1'b0, 1'b0, 16'h2346}) begin n_bad++; $display("FAIL add_cin: got v=%b ovf=%b cout=%b sum=%h want 1 0 0 2346", v, ov, co, s); end
  endtask

  task automatic test_overflow;
    logic e, v, co, ov;
    logic [15:0] s, want;
`ifdef CLA_PIPE_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'h8000;
`endif
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, v, s, co, ov);
    n_cmp++; if ({v, ov, co, s} !== {1'b1, 1'b1, 1'b0, want}) begin n_bad++; $display("FAIL pos_overflow: got v=%b ovf=%b cout=%b sum=%h want 1 1 0 %h", v, ov, co, s, want); end
  endtask

  task automatic test_subtract;
    logic e, v, co, ov;
    logic [15:0] s, want;
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, e, v, s, co, ov);
    n_cmp++; if ({v, ov, co, s} !== {1'b1, 1'b0, 1'b0, 16'hFFFE}) begin n_bad++; $display("FAIL sub_borrow: got v=%b ovf=%b cout=%b sum=%h want 1 0 0 fffe", v, ov, co, s); end
`ifdef CLA_PIPE_SATURATE_EN
    want = 16'h8000;
`else
    want = 16'h7FFF;
`endif
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, e, v, s, co, ov);
    n_cmp++; if ({v, ov, co, s} !== {1'b1, 1'b1, 1'b1, want}) begin n_bad++; $display("FAIL sub_neg_overflow: got v=%b ovf=%b cout=%b sum=%h want 1 1 1 %h", v, ov, co, s, want); end
    run_one(16'h0010, 16'h0003, 1'b1, 1'b1, e, v, s, co, ov);
    n_cmp++; if ({v, ov, co, s} !== {1'b1, 1'b0, 1'b1, 16'h000C}) begin n_bad++; $display("FAIL sub_borrow_in: got v=%b ovf=%b cout=%b sum=%h want 1 0 1 000c", v, ov, co, s); end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int nout = 0;
    logic fired = 1'b0;
    logic [15:0] expv;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 5);
      if (fired) in_valid = 1'b0;
      if (!in_valid && sent < 4) begin
        a = 16'(sent + 1); b = 16'(sent + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      #1;
      expv = 16'(2 * (nout + 1));
      if (c == 3) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
      end
      if (out_valid && !out_ready) begin
        n_cmp++; if (sum !== expv) begin n_bad++; $display("FAIL bp_stall_hold: got %h want %h", sum, expv); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (sum !== expv) begin n_bad++; $display("FAIL bp_order: got %h want %h", sum, expv); end
        nout++;
      end
      fired = in_valid && in_ready;
      if (fired) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (nout != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", nout); end
  endtask

  task automatic test_reset_midflight;
    logic e, v, co, ov;
    logic [15:0] s;
    int seen = 0;
    run_one(16'h1234, 16'h1111, 1'b1, 1'b0, e, v, s, co, ov);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, sum, cout, ovf} !== 19'd0) begin n_bad++; $display("FAIL midreset_async: got v=%b sum=%h cout=%b ovf=%b want all 0", out_valid, sum, cout, ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midreset_ghost: got %0d outputs want 0", seen); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL midreset_sum: got %h want 0000", sum); end
  endtask

  task automatic test_random;
    localparam int NOPS = 10000;
    logic [17:0] q[$];
    logic [17:0] e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic fired = 1'b0;
    while (got < NOPS && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = (sent >= NOPS) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (fired) in_valid = 1'b0;
      if (!in_valid && sent < NOPS && $urandom_range(0, 3) != 0) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: got sum=%h want no output", sum);
        end else begin
          e = q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_bad++; $display("FAIL rand_result #%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                              got, ovf, cout, sum, e[17], e[16], e[15:0]);
          end
        end
        got++;
      end
      fired = in_valid && in_ready;
      if (fired) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (got != NOPS) begin n_bad++; $display("FAIL rand_timeout: got %0d results want %0d", got, NOPS); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; rst_n = 1'b0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
